// File: rtl/md5_stream_padder_pkg.sv
// Shared MD5 constants, FSM state type and helpers for the stream padder and compression core.
package md5_pkg;

  localparam int unsigned MD5_BLK_W       = 512;
  localparam int unsigned MD5_BLK_BYTES   = 64;
  localparam int unsigned MD5_LEN_OFS     = 56;
  localparam int unsigned MD5_LEN_FIELD_W = 64;
  localparam int unsigned MD5_PTR_W       = 7;
  localparam logic [7:0]  MD5_PAD_BYTE    = 8'h80;

  // Initial chaining values consumed by the compression core
  localparam logic [31:0] MD5_IV_A = 32'h67452301;
  localparam logic [31:0] MD5_IV_B = 32'hefcdab89;
  localparam logic [31:0] MD5_IV_C = 32'h98badcfe;
  localparam logic [31:0] MD5_IV_D = 32'h10325476;

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    EMIT       = 2'd1,
    PAD        = 2'd2,
    EMIT_FINAL = 2'd3
  } md5_state_e;

  function automatic logic [63:0] md5_bswap64(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 8; i++) begin
      y[8*i +: 8] = x[8*(7-i) +: 8];
    end
    return y;
  endfunction

endpackage

// File: rtl/md5_stream_padder_if.sv
// Message-beat input stream and padded-block output stream of the MD5 padder.
interface md5_stream_padder_if #(
  parameter int unsigned IN_W = 32
);
  import md5_pkg::*;

  localparam int unsigned NB      = IN_W / 8;
  localparam int unsigned BYTES_W = $clog2(NB) + 1;

  logic [IN_W-1:0]      msg_in;
  logic                 msg_in_valid;
  logic                 msg_in_last;
  logic [BYTES_W-1:0]   msg_in_bytes;
  logic                 msg_in_ready;

  logic [MD5_BLK_W-1:0] blk_out;
  logic                 blk_out_valid;
  logic                 blk_out_first;
  logic                 blk_out_last;
  logic                 blk_out_ready;

  modport master (
    output msg_in, msg_in_valid, msg_in_last, msg_in_bytes, blk_out_ready,
    input  msg_in_ready, blk_out, blk_out_valid, blk_out_first, blk_out_last
  );

  modport slave (
    input  msg_in, msg_in_valid, msg_in_last, msg_in_bytes, blk_out_ready,
    output msg_in_ready, blk_out, blk_out_valid, blk_out_first, blk_out_last
  );

endinterface

// File: rtl/md5_stream_padder_len_insert.sv
// Places the bit-length counter into the 64-bit length field, zero-extended, LE or BE.
module md5_len_insert
  import md5_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic [LEN_W-1:0]           i_len,
  input  logic                       i_be,
  output logic [MD5_LEN_FIELD_W-1:0] o_field_c
);

  logic [MD5_LEN_FIELD_W-1:0] w_len64;

  assign w_len64   = MD5_LEN_FIELD_W'(i_len);
  assign o_field_c = i_be ? md5_bswap64(w_len64) : w_len64;

endmodule

// File: rtl/md5_stream_padder.sv
// Streaming MD5 padder: packs message beats into 512-bit blocks and appends 0x80, zeros and length.
// Optional MD5_PAD_BE_EN adds len_be to place the length big-endian (SHA style).
module md5_stream_padder
  import md5_pkg::*;
#(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned LEN_W = 64
) (
  input  logic                clk,
  input  logic                reset,
`ifdef MD5_PAD_BE_EN
  input  logic                len_be,
`endif
  md5_stream_padder_if.slave  bus
);

  localparam int unsigned NB      = IN_W / 8;
  localparam int unsigned BYTES_W = $clog2(NB) + 1;
  localparam int unsigned PTR_W   = MD5_PTR_W;
  localparam int unsigned LEN_HI  = MD5_BLK_W - 1;

  md5_state_e           r_state;
  logic [MD5_BLK_W-1:0] r_buf;
  logic [PTR_W-1:0]     r_ptr;
  logic [LEN_W-1:0]     r_len;
  logic                 r_pad80_done;
  logic                 r_pend_final;
  logic                 r_first_pend;
  logic                 r_len_be;
  logic                 r_in_ready;
  logic                 r_blk_valid;
  logic                 r_blk_first;
  logic                 r_blk_last;

  logic                       w_accept;
  logic                       w_blk_hs;
  logic                       w_blk_done;
  logic [BYTES_W-1:0]         w_nbytes;
  logic [PTR_W-1:0]           w_end;
  logic [LEN_W-1:0]           w_len_next;
  logic [LEN_W-1:0]           w_len_sel;
  logic                       w_be_in;
  logic                       w_be_sel;
  logic [MD5_LEN_FIELD_W-1:0] w_len_field;
  logic [MD5_BLK_W-1:0]       w_beat_sh;
  logic [MD5_BLK_W-1:0]       w_beat_mask;
  logic [MD5_BLK_W-1:0]       w_buf_fill;
  logic [MD5_BLK_W-1:0]       w_buf_pad;

  assign w_accept   = (r_state == FILL) && r_in_ready && bus.msg_in_valid;
  assign w_blk_hs   = r_blk_valid && bus.blk_out_ready;
  assign w_blk_done = (r_ptr + PTR_W'(NB)) == PTR_W'(MD5_BLK_BYTES);
  assign w_nbytes   = bus.msg_in_last ? bus.msg_in_bytes : BYTES_W'(NB);
  assign w_end      = r_ptr + PTR_W'(w_nbytes);
  assign w_len_next = r_len + (LEN_W'(w_nbytes) << 3);

`ifdef MD5_PAD_BE_EN
  assign w_be_in = len_be;
`else
  assign w_be_in = 1'b0;
`endif

  // One length placer serves both the last-beat block and the extra PAD block
  assign w_len_sel = (r_state == PAD) ? r_len : w_len_next;
  assign w_be_sel  = (r_state == PAD) ? r_len_be : w_be_in;

  md5_len_insert #(
    .LEN_W (LEN_W)
  ) u_len_insert (
    .i_len     (w_len_sel),
    .i_be      (w_be_sel),
    .o_field_c (w_len_field)
  );

  assign w_beat_sh   = MD5_BLK_W'(bus.msg_in) << {r_ptr, 3'b000};
  assign w_beat_mask = MD5_BLK_W'({IN_W{1'b1}}) << {r_ptr, 3'b000};

  // Buffer contents after writing the current beat, with tail padding on the last beat
  always_comb begin
    w_buf_fill = (r_buf & ~w_beat_mask) | w_beat_sh;
    if (bus.msg_in_last) begin
      for (int i = 0; i < int'(MD5_BLK_BYTES); i++) begin
        if (PTR_W'(i) >= w_end) begin
          w_buf_fill[8*i +: 8] = (PTR_W'(i) == w_end) ? MD5_PAD_BYTE : 8'h00;
        end
      end
      if (w_end < PTR_W'(MD5_LEN_OFS)) begin
        w_buf_fill[LEN_HI -: MD5_LEN_FIELD_W] = w_len_field;
      end
    end
  end

  always_comb begin
    w_buf_pad                             = '0;
    w_buf_pad[7:0]                        = r_pad80_done ? 8'h00 : MD5_PAD_BYTE;
    w_buf_pad[LEN_HI -: MD5_LEN_FIELD_W]  = w_len_field;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= FILL;
      r_buf        <= '0;
      r_ptr        <= '0;
      r_len        <= '0;
      r_pad80_done <= 1'b0;
      r_pend_final <= 1'b0;
      r_first_pend <= 1'b1;
      r_len_be     <= 1'b0;
      r_in_ready   <= 1'b0;
      r_blk_valid  <= 1'b0;
      r_blk_first  <= 1'b0;
      r_blk_last   <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_buf <= w_buf_fill;
            r_len <= w_len_next;
            r_ptr <= r_ptr + PTR_W'(NB);
            if (bus.msg_in_last) begin
              r_pad80_done <= (w_end < PTR_W'(MD5_BLK_BYTES));
              r_len_be     <= w_be_in;
              r_in_ready   <= 1'b0;
              r_blk_valid  <= 1'b1;
              r_blk_first  <= r_first_pend;
              if (w_end < PTR_W'(MD5_LEN_OFS)) begin
                r_blk_last <= 1'b1;
                r_state    <= EMIT_FINAL;
              end else begin
                r_pend_final <= 1'b1;
                r_state      <= EMIT;
              end
            end else if (w_blk_done) begin
              r_in_ready  <= 1'b0;
              r_blk_valid <= 1'b1;
              r_blk_first <= r_first_pend;
              r_state     <= EMIT;
            end
          end
        end
        EMIT: begin
          if (w_blk_hs) begin
            r_blk_valid  <= 1'b0;
            r_blk_first  <= 1'b0;
            r_first_pend <= 1'b0;
            if (r_pend_final) begin
              r_state <= PAD;
            end else begin
              r_buf      <= '0;
              r_ptr      <= '0;
              r_in_ready <= 1'b1;
              r_state    <= FILL;
            end
          end
        end
        PAD: begin
          r_buf        <= w_buf_pad;
          r_pend_final <= 1'b0;
          r_blk_valid  <= 1'b1;
          r_blk_first  <= r_first_pend;
          r_blk_last   <= 1'b1;
          r_state      <= EMIT_FINAL;
        end
        EMIT_FINAL: begin
          if (w_blk_hs) begin
            r_blk_valid  <= 1'b0;
            r_blk_first  <= 1'b0;
            r_blk_last   <= 1'b0;
            r_first_pend <= 1'b1;
            r_buf        <= '0;
            r_len        <= '0;
            r_ptr        <= '0;
            r_pad80_done <= 1'b0;
            r_in_ready   <= 1'b1;
            r_state      <= FILL;
          end
        end
        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

  assign bus.msg_in_ready  = r_in_ready;
  assign bus.blk_out       = r_buf;
  assign bus.blk_out_valid = r_blk_valid;
  assign bus.blk_out_first = r_blk_first;
  assign bus.blk_out_last  = r_blk_last;

endmodule

// File: tb/tb_md5_stream_padder.sv
// Directed self-checking bench for md5_stream_padder (IN_W=32, LEN_W=64).
module tb_md5_stream_padder;

  localparam int unsigned IN_W = 32;

  logic clk;
  logic reset;
`ifdef MD5_PAD_BE_EN
  logic len_be;
`endif

  md5_stream_padder_if #(.IN_W(IN_W)) bus ();

  md5_stream_padder #(
    .IN_W  (IN_W),
    .LEN_W (64)
  ) dut (
    .clk    (clk),
    .reset  (reset),
`ifdef MD5_PAD_BE_EN
    .len_be (len_be),
`endif
    .bus    (bus)
  );

  typedef struct {
    logic [511:0] d;
    logic         f;
    logic         l;
  } blk_t;

  blk_t       q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] g_msg [0:127];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every block whose handshake completes on the following rising edge
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.blk_out_valid === 1'b1 && bus.blk_out_ready === 1'b1)
      q.push_back('{d: bus.blk_out, f: bus.blk_out_first, l: bus.blk_out_last});
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [511:0] msg_blk(input int off, input int cnt);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < cnt; k++) r[8*k +: 8] = g_msg[off+k];
    return r;
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic lst, input logic [2:0] nb);
    int cnt;
    cnt = 0;
    bus.msg_in       = d;
    bus.msg_in_last  = lst;
    bus.msg_in_bytes = nb;
    bus.msg_in_valid = 1'b1;
    while (bus.msg_in_ready !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (bus.msg_in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_beat_timeout ready=%b required 1", bus.msg_in_ready);
    end else begin
      @(posedge clk);
      #1;
    end
    bus.msg_in_valid = 1'b0;
    bus.msg_in_last  = 1'b0;
  endtask

  task automatic send_range(input int n, input int b0, input int b1);
    logic [31:0] d;
    int          nb;
    int          nbt;
    logic        lst;
    nbt = (n == 0) ? 1 : (n + 3) / 4;
    for (int b = b0; b < b1; b++) begin
      lst = (b == nbt - 1);
      nb  = lst ? n - 4*b : 4;
      for (int k = 0; k < 4; k++) d[8*k +: 8] = (k < nb) ? g_msg[4*b+k] : 8'hEE;
      send_beat(d, lst, 3'(nb));
    end
  endtask

  task automatic wait_blocks(input int cnt);
    int t;
    t = 0;
    while (q.size() < cnt && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset             = 1'b0;
    bus.msg_in        = '0;
    bus.msg_in_valid  = 1'b0;
    bus.msg_in_last   = 1'b0;
    bus.msg_in_bytes  = '0;
    bus.blk_out_ready = 1'b1;
`ifdef MD5_PAD_BE_EN
    len_be            = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.msg_in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", bus.msg_in_ready); end
    checks++; if (bus.blk_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", bus.blk_out_valid); end
    checks++; if (bus.blk_out_first !== 1'b0) begin errors++; $display("FAIL rst_first got=%b exp=0", bus.blk_out_first); end
    checks++; if (bus.blk_out_last !== 1'b0) begin errors++; $display("FAIL rst_last got=%b exp=0", bus.blk_out_last); end
    checks++; if (bus.blk_out !== 512'h0) begin errors++; $display("FAIL rst_blk got=%h exp=0", bus.blk_out); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.msg_in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got=%b exp=1", bus.msg_in_ready); end
  endtask

  task automatic test_empty();
    logic [511:0] exp;
    q.delete();
    send_beat(32'hEEEEEEEE, 1'b1, 3'd0);
    checks++; if (bus.blk_out_valid !== 1'b1) begin errors++; $display("FAIL empty_latency valid=%b exp=1", bus.blk_out_valid); end
    checks++; if (bus.msg_in_ready !== 1'b0) begin errors++; $display("FAIL empty_stall ready=%b exp=0", bus.msg_in_ready); end
    wait_blocks(1);
    exp = 512'h80;
    checks++; if (q.size() != 1) begin errors++; $display("FAIL empty_count got=%0d exp=1", q.size()); end
    checks++; if (q[0].d !== exp) begin errors++; $display("FAIL empty_data got=%h exp=%h", q[0].d, exp); end
    checks++; if (q[0].f !== 1'b1) begin errors++; $display("FAIL empty_first got=%b exp=1", q[0].f); end
    checks++; if (q[0].l !== 1'b1) begin errors++; $display("FAIL empty_last got=%b exp=1", q[0].l); end
  endtask

  task automatic test_abc();
    logic [511:0] exp;
    q.delete();
    g_msg[0] = 8'h61; g_msg[1] = 8'h62; g_msg[2] = 8'h63;
    send_range(3, 0, 1);
    wait_blocks(1);
    exp = '0;
    exp[31:0]      = 32'h80636261;
    exp[8*56 +: 8] = 8'h18;
    checks++; if (q.size() != 1) begin errors++; $display("FAIL abc_count got=%0d exp=1", q.size()); end
    checks++; if (q[0].d !== exp) begin errors++; $display("FAIL abc_data got=%h exp=%h", q[0].d, exp); end
    checks++; if (q[0].f !== 1'b1 || q[0].l !== 1'b1) begin errors++; $display("FAIL abc_flags got=%b%b exp=11", q[0].f, q[0].l); end
  endtask

  task automatic test_55_56();
    logic [511:0] exp;
    for (int i = 0; i < 128; i++) g_msg[i] = 8'(i + 1);
    q.delete();
    send_range(55, 0, 14);
    wait_blocks(1);
    exp = msg_blk(0, 55);
    exp[8*55 +: 8] = 8'h80; exp[8*56 +: 8] = 8'hB8; exp[8*57 +: 8] = 8'h01;
    checks++; if (q.size() != 1) begin errors++; $display("FAIL m55_count got=%0d exp=1", q.size()); end
    checks++; if (q[0].d !== exp) begin errors++; $display("FAIL m55_data got=%h exp=%h", q[0].d, exp); end
    checks++; if (q[0].f !== 1'b1 || q[0].l !== 1'b1) begin errors++; $display("FAIL m55_flags got=%b%b exp=11", q[0].f, q[0].l); end

    q.delete();
    send_range(56, 0, 14);
    wait_blocks(2);
    checks++; if (q.size() != 2) begin errors++; $display("FAIL m56_count got=%0d exp=2", q.size()); end
    exp = msg_blk(0, 56);
    exp[8*56 +: 8] = 8'h80;
    checks++; if (q[0].d !== exp) begin errors++; $display("FAIL m56_blk0 got=%h exp=%h", q[0].d, exp); end
    checks++; if (q[0].f !== 1'b1 || q[0].l !== 1'b0) begin errors++; $display("FAIL m56_flags0 got=%b%b exp=10", q[0].f, q[0].l); end
    exp = '0;
    exp[8*56 +: 8] = 8'hC0; exp[8*57 +: 8] = 8'h01;
    checks++; if (q[1].d !== exp) begin errors++; $display("FAIL m56_blk1 got=%h exp=%h", q[1].d, exp); end
    checks++; if (q[1].f !== 1'b0 || q[1].l !== 1'b1) begin errors++; $display("FAIL m56_flags1 got=%b%b exp=01", q[1].f, q[1].l); end
  endtask

  task automatic test_64();
    logic [511:0] exp;
    for (int i = 0; i < 128; i++) g_msg[i] = 8'(3*i + 5);
    q.delete();
    send_range(64, 0, 16);
    wait_blocks(2);
    checks++; if (q.size() != 2) begin errors++; $display("FAIL m64_count got=%0d exp=2", q.size()); end
    exp = msg_blk(0, 64);
    checks++; if (q[0].d !== exp) begin errors++; $display("FAIL m64_blk0 got=%h exp=%h", q[0].d, exp); end
    checks++; if (q[0].f !== 1'b1 || q[0].l !== 1'b0) begin errors++; $display("FAIL m64_flags0 got=%b%b exp=10", q[0].f, q[0].l); end
    exp = '0;
    exp[7:0] = 8'h80; exp[8*57 +: 8] = 8'h02;
    checks++; if (q[1].d !== exp) begin errors++; $display("FAIL m64_blk1 got=%h exp=%h", q[1].d, exp); end
    checks++; if (q[1].f !== 1'b0 || q[1].l !== 1'b1) begin errors++; $display("FAIL m64_flags1 got=%b%b exp=01", q[1].f, q[1].l); end
  endtask

  task automatic test_zero_last();
    logic [511:0] exp;
    logic [31:0]  d;
    for (int i = 0; i < 128; i++) g_msg[i] = 8'(255 - i);
    q.delete();
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 4; k++) d[8*k +: 8] = g_msg[4*b+k];
      send_beat(d, 1'b0, 3'd4);
    end
    send_beat(32'hEEEEEEEE, 1'b1, 3'd0);
    wait_blocks(2);
    checks++; if (q.size() != 2) begin errors++; $display("FAIL zl_count got=%0d exp=2", q.size()); end
    exp = msg_blk(0, 64);
    checks++; if (q[0].d !== exp) begin errors++; $display("FAIL zl_blk0 got=%h exp=%h", q[0].d, exp); end
    exp = '0;
    exp[7:0] = 8'h80; exp[8*57 +: 8] = 8'h02;
    checks++; if (q[1].d !== exp) begin errors++; $display("FAIL zl_blk1 got=%h exp=%h", q[1].d, exp); end
    checks++; if (q[0].f !== 1'b1 || q[0].l !== 1'b0 || q[1].f !== 1'b0 || q[1].l !== 1'b1) begin
      errors++; $display("FAIL zl_flags got=%b%b%b%b exp=1001", q[0].f, q[0].l, q[1].f, q[1].l);
    end
  endtask

  task automatic test_backpressure();
    string        s;
    logic [511:0] exp;
    logic [511:0] hold;
    int           bad;
    s = "message digest";
    for (int i = 0; i < 119; i++) g_msg[i] = s[i % 14];
    q.delete();
    bus.blk_out_ready = 1'b0;
    send_range(119, 0, 16);
    hold = bus.blk_out;
    bad  = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.blk_out !== hold || bus.blk_out_valid !== 1'b1 || bus.msg_in_ready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable bad_cycles=%0d exp=0", bad); end
    exp = msg_blk(0, 64);
    checks++; if (hold !== exp) begin errors++; $display("FAIL bp_held got=%h exp=%h", hold, exp); end
    @(posedge clk);
    #1;
    bus.blk_out_ready = 1'b1;
    send_range(119, 16, 30);
    wait_blocks(2);
    checks++; if (q.size() != 2) begin errors++; $display("FAIL bp_count got=%0d exp=2", q.size()); end
    checks++; if (q[0].d !== exp) begin errors++; $display("FAIL bp_blk0 got=%h exp=%h", q[0].d, exp); end
    exp = msg_blk(64, 55);
    exp[8*55 +: 8] = 8'h80; exp[8*56 +: 8] = 8'hB8; exp[8*57 +: 8] = 8'h03;
    checks++; if (q[1].d !== exp) begin errors++; $display("FAIL bp_blk1 got=%h exp=%h", q[1].d, exp); end
    checks++; if (q[0].f !== 1'b1 || q[0].l !== 1'b0 || q[1].f !== 1'b0 || q[1].l !== 1'b1) begin
      errors++; $display("FAIL bp_flags got=%b%b%b%b exp=1001", q[0].f, q[0].l, q[1].f, q[1].l);
    end
  endtask

  task automatic test_reset_mid();
    logic [511:0] exp;
    for (int i = 0; i < 128; i++) g_msg[i] = 8'(i ^ 8'h5A);
    send_range(40, 0, 3);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    q.delete();
    g_msg[0] = 8'h61;
    send_range(1, 0, 1);
    wait_blocks(1);
    exp = '0;
    exp[15:0]      = 16'h8061;
    exp[8*56 +: 8] = 8'h08;
    checks++; if (q.size() != 1) begin errors++; $display("FAIL rmid_count got=%0d exp=1", q.size()); end
    checks++; if (q[0].d !== exp) begin errors++; $display("FAIL rmid_data got=%h exp=%h", q[0].d, exp); end
    checks++; if (q[0].f !== 1'b1 || q[0].l !== 1'b1) begin errors++; $display("FAIL rmid_flags got=%b%b exp=11", q[0].f, q[0].l); end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_abc();
    test_55_56();
    test_64();
    test_zero_last();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md5_stream_padder.md
# md5_stream_padder

Streaming MD5 front-end that removes the 128-bit single-message limit of the current pancham datapath. It accepts a message of any length as a stream of IN_W-bit beats and emits MD5-padded 512-bit blocks: the message, then 0x80, zero fill, and the 64-bit bit length. It sits between the host/bus interface and a block-compression core, which chains A/B/C/D across the emitted blocks.

## Interface
- IN_W, 32: input beat width in bits. Legal values: 32, 64, 128. NB = IN_W/8 bytes per beat.
- LEN_W, 64: width of the internal bit-length counter. Legal range is 16..64; bits above LEN_W in the length field are zero.
- clk  in  1  clock; all logic rises on posedge.
- reset  in  1  synchronous, active-low reset.
- msg_in  in  IN_W  message beat. Byte k is msg_in[8k+7:8k]; byte 0 is first in message order.
- msg_in_valid  in  1  beat valid.
- msg_in_last  in  1  final beat of the message.
- msg_in_bytes  in  $clog2(NB)+1  valid bytes on the last beat, 0..NB. Ignored when msg_in_last=0 (all NB bytes are valid).
- msg_in_ready  out  1  beat accepted when valid && ready.
- blk_out  out  512  padded block. Byte k is blk_out[8k+7:8k].
- blk_out_valid  out  1  block valid.
- blk_out_first  out  1  first block of a message.
- blk_out_last  out  1  final block of a message.
- blk_out_ready  in  1  block consumed when valid && ready.

## Operation
- State machine: FILL, EMIT, PAD, EMIT_FINAL.
- **FILL**
  - msg_in_ready=1.
  - Each accepted beat is written at byte pointer ptr (a multiple of NB). ptr advances by NB, and len advances by 8*bytes, modulo 2^LEN_W.
  - A non-last beat that reaches ptr=64 goes to EMIT.
- **Last beat accepted** (with b = msg_in_bytes, end = ptr + b)
  - Bytes end..63 are zeroed.
  - If end < 64: byte end = 0x80 (set flag pad80_done).
  - If end <= 55: bytes 56..63 = final len, little-endian. Go to EMIT_FINAL.
  - Otherwise: go to EMIT with pending-final set.
- **EMIT**
  - blk_out_valid=1 and msg_in_ready=0.
  - On handshake: if pending-final, go to PAD; else clear the buffer, set ptr=0, go to FILL.
- **PAD**
  - Builds the extra block in one cycle: byte0 = 0x80 if !pad80_done, else 0; bytes 1..55 = 0; bytes 56..63 = len.
  - Then goes to EMIT_FINAL.
- **EMIT_FINAL**
  - blk_out_valid=1 and blk_out_last=1.
  - On handshake: clear len, pad80_done and ptr; go to FILL.
- **blk_out_first**
  - Set on the first block emitted after reset or after a final block; cleared after that block's handshake.
- **Empty message**: a last beat with bytes=0 at ptr=0 gives one block with byte0=0x80 and len=0.
- **Zero-byte last beat after a full block**: when ptr=0 and the previous block was already emitted, it pads a fresh block; no empty block is emitted.

## Timing
- Reset values:
  - msg_in_ready=0 during reset, 1 from the first cycle after reset.
  - blk_out_valid=0, blk_out_first=0, blk_out_last=0, blk_out=0.
  - State FILL, ptr=0, len=0.
- Latency:
  - The block is valid in the cycle after the beat that completes it.
  - The PAD block is valid 2 cycles after the EMIT handshake (one PAD cycle, then EMIT_FINAL).
- Output stability: blk_out and its flags are held stable while valid && !ready.
- Throughput: one stall cycle per block, plus one PAD cycle for messages needing an extra block.
- Backpressure: msg_in_ready=0 throughout EMIT, PAD and EMIT_FINAL. Beats are never dropped or duplicated.
- Length wrap: len wraps at 2^LEN_W silently, with no error.
- Reset mid-operation: the partial message and any held block are discarded; the next message starts with first=1.

## Configuration
- MD5_PAD_BE_EN defined:
  - Adds input port len_be (1 bit), sampled with the last beat.
  - len_be=1 places the length big-endian in bytes 56..63 (SHA-1/SHA-256 style).
- MD5_PAD_BE_EN undefined:
  - The port is absent and the length is always little-endian (MD5).
  - No other behaviour differs.

## Structure
- Package md5_pkg holds:
  - MD5_BLK_W=512, MD5_BLK_BYTES=64, MD5_LEN_OFS=56, MD5_PAD_BYTE=8'h80.
  - The state enum typedef.
  - The IV constants shared with the compression core.
- One sub-module, md5_len_insert: a combinational length field placer that handles endianness and zero-extension from LEN_W to 64 bits.

## Test plan
- Empty message (IN_W=32, a single beat with last=1, bytes=0) -> one block; byte0=0x80; bytes 1..63 = 0; first=1, last=1.
- "abc" (one beat 0x00636261, bytes=3) -> one block with bytes 0..3 = 61 62 63 80, byte56=0x18, all other bytes 0.
- 55-byte message -> one block with byte55=0x80, byte56=0xB8, byte57=0x01. 56-byte message -> two blocks: the first ends with 0x80 at byte56; the second has 0x00 at byte0, then byte56=0xC0, byte57=0x01; last=1 only on the second.
- 64-byte message (IN_W=64, 8 beats, last beat bytes=8) -> two blocks; the second has byte0=0x80 and bytes 56/57 = 0x00/0x02.
- Backpressure: with blk_out_ready held 0 for 5 cycles during EMIT, blk_out is stable, msg_in_ready=0, and no beat is lost. The 119-byte ("message digest"×8+7) reference matches software MD5 after the core.
- Reset asserted mid-FILL -> the next message "a" produces one block 0x61,0x80 with length 0x08, and first=1.
